// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Operands are split into BLOCK_WIDTH-bit lookahead blocks, BLOCKS_PER_STAGE of which
// are resolved per pipeline stage; the carry between stages is registered.
// Optional signed-overflow and zero flags are built when CLA_ADDSUB_FLAGS_EN is defined.
module cla_pipelined_addsub #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BLOCK_WIDTH      = 4,
    parameter int unsigned BLOCKS_PER_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  out_zero
);

    localparam int unsigned NumBlocks  = (DATA_WIDTH + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
    localparam int unsigned NumStages  = (NumBlocks + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    localparam int unsigned StageWidth = BLOCKS_PER_STAGE * BLOCK_WIDTH;
    localparam int unsigned PadWidth   = NumStages * StageWidth;
    localparam bit          HasPad     = (DATA_WIDTH < PadWidth);
    // With zero-padded operands, the sum bit just above the MSB equals the carry into it.
    localparam int unsigned CoutIdx    = HasPad ? DATA_WIDTH : PadWidth - 1;

    // One lookahead block: every internal carry is a flat sum-of-products of g/p/cin.
    // Returns {carry_out, sum}.
    function automatic logic [BLOCK_WIDTH:0] cla_block(input logic [BLOCK_WIDTH-1:0] a,
                                                       input logic [BLOCK_WIDTH-1:0] b,
                                                       input logic               cin);
        logic [BLOCK_WIDTH-1:0] g;
        logic [BLOCK_WIDTH-1:0] p;
        logic [BLOCK_WIDTH:0]   c;
        logic                   term;
        logic                   prod;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK_WIDTH); i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = term | (cin & prod);
        end
        return {c[BLOCK_WIDTH], p ^ c[BLOCK_WIDTH-1:0]};
    endfunction

    logic                  advance;
    logic [NumStages-1:0]  valid_q, valid_d;
    logic [PadWidth-1:0]   a_src   [NumStages];
    logic [PadWidth-1:0]   b_src   [NumStages];
    logic [PadWidth-1:0]   sum_src [NumStages];
    logic                  carry_src [NumStages];
    logic                  sub_src   [NumStages];
    logic [PadWidth-1:0]   a_q     [NumStages];
    logic [PadWidth-1:0]   b_q     [NumStages];
    logic [PadWidth-1:0]   sum_q   [NumStages];
    logic [PadWidth-1:0]   sum_d   [NumStages];
    logic                  carry_q [NumStages];
    logic                  carry_d [NumStages];
    logic                  sub_q   [NumStages];
    logic                  cout_d, cout_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    // Stage inputs: stage 0 takes the (padded, conditionally inverted) operands,
    // later stages take the register of the stage before.
    always_comb begin
        a_src[0]          = '0;
        a_src[0][DATA_WIDTH-1:0] = in_a;
        b_src[0]          = '0;
        b_src[0][DATA_WIDTH-1:0] = in_sub ? ~in_b : in_b;
        sum_src[0]        = '0;
        carry_src[0]      = in_cin ^ in_sub;
        sub_src[0]        = in_sub;
        valid_d[0]        = in_valid;
        for (int k = 1; k < int'(NumStages); k++) begin
            a_src[k]     = a_q[k-1];
            b_src[k]     = b_q[k-1];
            sum_src[k]   = sum_q[k-1];
            carry_src[k] = carry_q[k-1];
            sub_src[k]   = sub_q[k-1];
            valid_d[k]   = valid_q[k-1];
        end
    end

    // Each stage resolves its own slice of blocks, rippling the carry block to block.
    always_comb begin : stage_comb
        logic                 carry;
        logic [BLOCK_WIDTH:0] blk;
        carry  = 1'b0;
        blk    = '0;
        cout_d = 1'b0;
        for (int k = 0; k < int'(NumStages); k++) begin
            sum_d[k] = sum_src[k];
            carry    = carry_src[k];
            for (int j = 0; j < int'(BLOCKS_PER_STAGE); j++) begin
                blk = cla_block(a_src[k][k*StageWidth + j*BLOCK_WIDTH +: BLOCK_WIDTH],
                                b_src[k][k*StageWidth + j*BLOCK_WIDTH +: BLOCK_WIDTH],
                                carry);
                sum_d[k][k*StageWidth + j*BLOCK_WIDTH +: BLOCK_WIDTH] = blk[BLOCK_WIDTH-1:0];
                carry = blk[BLOCK_WIDTH];
            end
            carry_d[k] = carry;
        end
        // Never take the padded block's carry-out when the top block is partial.
        if (HasPad) begin
            cout_d = sum_d[NumStages-1][CoutIdx];
        end else begin
            cout_d = carry_d[NumStages-1];
        end
    end

    // All stages shift together on advance and hold otherwise; only the output stage resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q              <= '0;
            sum_q[NumStages-1]   <= '0;
            cout_q               <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            a_q     <= a_src;
            b_q     <= b_src;
            carry_q <= carry_d;
            sub_q   <= sub_src;
            cout_q  <= cout_d;
        end
    end

    assign out_valid = valid_q[NumStages-1];
    assign out_sum   = sum_q[NumStages-1][DATA_WIDTH-1:0];
    assign out_cout  = cout_q;

`ifdef CLA_ADDSUB_FLAGS_EN
    logic sign_a_src [NumStages];
    logic sign_b_src [NumStages];
    logic sign_a_q   [NumStages];
    logic sign_b_q   [NumStages];
    logic ovf_d, ovf_q;
    logic zero_d, zero_q;

    // Operand sign bits travel with the beat so overflow can be judged at the last stage.
    always_comb begin
        sign_a_src[0] = in_a[DATA_WIDTH-1];
        sign_b_src[0] = in_sub ? ~in_b[DATA_WIDTH-1] : in_b[DATA_WIDTH-1];
        for (int k = 1; k < int'(NumStages); k++) begin
            sign_a_src[k] = sign_a_q[k-1];
            sign_b_src[k] = sign_b_q[k-1];
        end
        ovf_d  = (sign_a_src[NumStages-1] == sign_b_src[NumStages-1]) &&
                 (sum_d[NumStages-1][DATA_WIDTH-1] != sign_a_src[NumStages-1]);
        zero_d = ~|sum_d[NumStages-1][DATA_WIDTH-1:0];
    end

    // Flags are registered alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            sign_a_q <= sign_a_src;
            sign_b_q <= sign_b_src;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Directed and backpressure checks for cla_pipelined_addsub at default and odd geometry.
module tb_cla_pipelined_addsub;

    localparam int NS  = 4;   // stages, default geometry
    localparam int ONS = 2;   // stages, 13/4/3 geometry
`ifdef CLA_ADDSUB_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry DUT
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_cin = 1'b0, in_sub = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout, out_ovf, out_zero;

    // Odd-geometry DUT
    logic        odd_rst = 1'b1;
    logic        odd_in_valid = 1'b0, odd_in_ready;
    logic [12:0] odd_in_a = '0, odd_in_b = '0;
    logic        odd_in_cin = 1'b0, odd_in_sub = 1'b0;
    logic        odd_out_valid, odd_out_ready = 1'b1;
    logic [12:0] odd_out_sum;
    logic        odd_out_cout, odd_out_ovf, odd_out_zero;

    int n_vec  = 0;
    int n_fail = 0;

    cla_pipelined_addsub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    cla_pipelined_addsub #(
        .DATA_WIDTH       (13),
        .BLOCK_WIDTH      (4),
        .BLOCKS_PER_STAGE (3)
    ) dut_odd (
        .clk       (clk),
        .rst       (odd_rst),
        .in_valid  (odd_in_valid),
        .in_ready  (odd_in_ready),
        .in_a      (odd_in_a),
        .in_b      (odd_in_b),
        .in_cin    (odd_in_cin),
        .in_sub    (odd_in_sub),
        .out_valid (odd_out_valid),
        .out_ready (odd_out_ready),
        .out_sum   (odd_out_sum),
        .out_cout  (odd_out_cout),
        .out_ovf   (odd_out_ovf),
        .out_zero  (odd_out_zero)
    );

    // Reference: {ovf, zero, cout, sum} from a plain wide addition.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] r;
        logic        ovf, zero;
        be   = sub ? ~b : b;
        r    = {1'b0, a} + {1'b0, be} + {32'd0, cin ^ sub};
        ovf  = (a[31] == be[31]) && (r[31] != a[31]);
        zero = (r[31:0] == 32'd0);
        return {ovf & FlagsEn, zero & FlagsEn, r[32], r[31:0]};
    endfunction

    // Present one beat with out_ready=1 and wait for it; lat counts edges from accept.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, output logic [34:0] res, output int lat);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        res = '0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            if (out_valid) begin
                res = {out_ovf, out_zero, out_cout, out_sum};
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
                     out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_vec++;
        if (odd_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_odd_valid: got %b want 0", odd_out_valid);
        end
        rst = 1'b0;
        odd_rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [34:0] r;
        int          lat;
        run_beat(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, r, lat);
        n_vec++;
        if (r !== {1'b0, 1'b0, 1'b0, 32'h0000_0008} || lat != NS) begin
            n_fail++;
            $display("FAIL add_5_3: got res=%h lat=%0d want res=%h lat=%0d",
                     r, lat, {3'b000, 32'h8}, NS);
        end
    endtask

    task automatic test_carry_ripple();
        logic [34:0] r;
        int          lat;
        run_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat);
        n_vec++;
        if (r !== {1'b0, FlagsEn, 1'b1, 32'h0000_0000} || lat != NS) begin
            n_fail++;
            $display("FAIL carry_ripple: got res=%h lat=%0d want res=%h lat=%0d",
                     r, lat, {1'b0, FlagsEn, 1'b1, 32'h0}, NS);
        end
    endtask

    task automatic test_subtract();
        logic [34:0] r;
        int          lat;
        run_beat(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, r, lat);
        n_vec++;
        if (r !== {3'b000, 32'hFFFF_FFFE}) begin
            n_fail++;
            $display("FAIL sub_3_5: got %h want %h", r, {3'b000, 32'hFFFF_FFFE});
        end
        run_beat(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, r, lat);
        n_vec++;
        if (r !== {3'b000, 32'hFFFF_FFFD}) begin
            n_fail++;
            $display("FAIL sub_3_5_borrow: got %h want %h", r, {3'b000, 32'hFFFF_FFFD});
        end
    endtask

    task automatic test_overflow();
        logic [34:0] r;
        int          lat;
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat);
        n_vec++;
        if (r !== {FlagsEn, 1'b0, 1'b0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL ovf_add: got %h want %h", r, {FlagsEn, 2'b00, 32'h8000_0000});
        end
        run_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, r, lat);
        n_vec++;
        if (r !== {FlagsEn, 1'b0, 1'b1, 32'h7FFF_FFFF}) begin
            n_fail++;
            $display("FAIL ovf_sub: got %h want %h", r, {FlagsEn, 2'b01, 32'h7FFF_FFFF});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [16];
        logic [31:0] bv [16];
        logic        cv [16];
        logic        sv [16];
        logic [34:0] expq [$];
        logic [34:0] exp_r, held;
        int          sent, recv, extra, idx;
        logic        prev_stall;
        for (int i = 0; i < 16; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
            cv[i] = 1'($urandom_range(0, 1));
            sv[i] = 1'($urandom_range(0, 1));
        end
        av[3] = 32'hFFFF_FFFF; bv[3] = 32'h0000_0001; sv[3] = 1'b0; cv[3] = 1'b0;
        sent = 0; recv = 0; prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 500 && recv < 16; cyc++) begin
            @(posedge clk); #1;
            idx       = (sent < 16) ? sent : 0;
            in_valid  = (sent < 16);
            in_a      = av[idx];
            in_b      = bv[idx];
            in_cin    = cv[idx];
            in_sub    = sv[idx];
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || {out_ovf, out_zero, out_cout, out_sum} !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b res=%h want valid=1 res=%h",
                             out_valid, {out_ovf, out_zero, out_cout, out_sum}, held);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(av[sent], bv[sent], cv[sent], sv[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_dup: got res=%h want no beat",
                             {out_ovf, out_zero, out_cout, out_sum});
                end else begin
                    exp_r = expq.pop_front();
                    if ({out_ovf, out_zero, out_cout, out_sum} !== exp_r) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d: got %h want %h", recv,
                                 {out_ovf, out_zero, out_cout, out_sum}, exp_r);
                    end
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            held = {out_ovf, out_zero, out_cout, out_sum};
        end
        n_vec++;
        if (recv != 16 || sent != 16) begin
            n_fail++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d want 16/16", sent, recv);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL b2b_extra: got %0d extra beats want 0", extra);
        end
    endtask

    task automatic test_odd_geometry();
        int   lat, stale;
        logic got;
        @(posedge clk); #1;
        odd_in_a = 13'h1FFF; odd_in_b = 13'h0001; odd_in_cin = 1'b0; odd_in_sub = 1'b0;
        odd_in_valid = 1'b1;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            odd_in_valid = 1'b0;
            lat++;
            got = odd_out_valid;
        end
        n_vec++;
        if ({odd_out_ovf, odd_out_zero, odd_out_cout, odd_out_sum} !==
                {1'b0, FlagsEn, 1'b1, 13'h0000} || lat != ONS || !got) begin
            n_fail++;
            $display("FAIL odd_wrap: got res=%h lat=%0d want res=%h lat=%0d",
                     {odd_out_ovf, odd_out_zero, odd_out_cout, odd_out_sum}, lat,
                     {1'b0, FlagsEn, 1'b1, 13'h0}, ONS);
        end
        // Two beats in flight, then reset
        odd_in_a = 13'h0001; odd_in_b = 13'h0002; odd_in_valid = 1'b1;
        @(posedge clk); #1;
        odd_in_a = 13'h0003; odd_in_b = 13'h0004;
        @(posedge clk); #1;
        odd_in_valid = 1'b0;
        n_vec++;
        if (odd_out_valid !== 1'b1 || odd_out_sum !== 13'h0003) begin
            n_fail++;
            $display("FAIL odd_inflight: got valid=%b sum=%h want valid=1 sum=0003",
                     odd_out_valid, odd_out_sum);
        end
        odd_rst = 1'b1;
        #1;
        n_vec++;
        if (odd_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_rst_in_ready: got %b want 0", odd_in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (odd_out_valid !== 1'b0 || odd_out_sum !== 13'h0 || odd_out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_rst_flush: got valid=%b sum=%h cout=%b want 0/0000/0",
                     odd_out_valid, odd_out_sum, odd_out_cout);
        end
        odd_rst = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (odd_out_valid) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL odd_stale: got %0d stale beats want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_ripple();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_odd_geometry();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
